// File: rtl/vote_logger_pkg.sv
// Shared definitions for the vote logger: ballot FSM states, default sizes
// and the saturation ceiling helper used by every counter.
// Pure declarations; no logic, no latency, no flow control.
package vote_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      ARMED = 1'b1
   } state_e;

   localparam int DEF_NUM_CAND = 4;
   localparam int DEF_CNT_W    = 8;

   // All-ones value of a w-bit counter, i.e. the level it saturates at.
   function automatic logic [31:0] sat_max(input int w);
      if (w >= 32) begin
         return '1;
      end
      return (32'd1 << w) - 32'd1;
   endfunction

endpackage

// File: rtl/vote_logger_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
// Latency: count reflects inc/clr one edge after they are sampled.
// Backpressure: none; an increment at the ceiling is silently absorbed.
module sat_counter
   import vote_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt_o
);

   localparam logic [CNT_W-1:0] MAX = CNT_W'(sat_max(CNT_W));

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: clear wins, otherwise step up unless already at the ceiling.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/vote_logger.sv
// Ballot-gated vote recorder: one unambiguous vote per armed ballot, per-candidate tallies, readout mux.
// Latency: ack/reject/timeout pulses and counters update one edge after the vote; readout is 1 cycle.
// Backpressure: none; votes outside an armed ballot are dropped, ambiguous votes counted and rejected.
module vote_logger
   import vote_pkg::*;
#(
   parameter int NUM_CAND = DEF_NUM_CAND,
   parameter int CNT_W    = DEF_CNT_W,
   parameter int TIMEOUT  = 1000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                ballot_arm,
   input  logic [NUM_CAND-1:0] valid_vote,
   input  logic                mode,
   input  logic [3:0]          result_sel,
   input  logic                clear_all,
   output logic                ballot_ready,
   output logic                vote_ack,
   output logic                vote_reject,
   output logic                ballot_timeout,
   output logic [CNT_W-1:0]    result_count,
   output logic [CNT_W-1:0]    total_votes,
   output logic [CNT_W-1:0]    reject_count
);

   // The timer never runs past TIMEOUT-1: the ballot always leaves ARMED there.
   localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   state_e             state_q, state_d;
   logic [TMR_W-1:0]   timer_q, timer_d;
   logic               ack_q, ack_d;
   logic               rej_q, rej_d;
   logic               to_q, to_d;
   logic [CNT_W-1:0]   result_q, result_d;

   logic [4:0]          pop_cnt;
   logic                one_hot;
   logic                multi;
   logic                expired;
   logic                clear_en;
   logic [NUM_CAND-1:0] tally_inc;
   logic                total_inc;
   logic                rej_inc;
   logic [CNT_W-1:0]    tally [NUM_CAND];

   // Population count of the vote vector; decides single vs ambiguous without ranking bits.
   always_comb begin
      pop_cnt = '0;
      for (int i = 0; i < NUM_CAND; i++) begin
         pop_cnt = pop_cnt + 5'(valid_vote[i]);
      end
   end

   assign one_hot  = (pop_cnt == 5'd1);
   assign multi    = (pop_cnt > 5'd1);
   assign expired  = (timer_q == TMR_W'(TIMEOUT - 1));
   assign clear_en = clear_all && mode;

   // Ballot FSM: arming, vote acceptance/rejection, expiry and pulse generation.
   // An ambiguous vote in the expiry cycle is still counted as rejected, and the
   // ballot expires anyway since no valid vote arrived in time.
   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      ack_d     = 1'b0;
      rej_d     = 1'b0;
      to_d      = 1'b0;
      tally_inc = '0;
      total_inc = 1'b0;
      rej_inc   = 1'b0;
      case (state_q)
         IDLE: begin
            if (ballot_arm && !mode) begin
               state_d = ARMED;
               timer_d = '0;
            end
         end
         ARMED: begin
            if (mode) begin
               state_d = IDLE;
            end else if (one_hot) begin
               // Exactly one bit is set, so the vote vector is itself the one-hot select.
               tally_inc = valid_vote;
               total_inc = 1'b1;
               ack_d     = 1'b1;
               state_d   = IDLE;
            end else begin
               if (multi) begin
                  rej_inc = 1'b1;
                  rej_d   = 1'b1;
               end
               if (expired) begin
                  to_d    = 1'b1;
                  state_d = IDLE;
               end else begin
                  timer_d = timer_q + TMR_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Readout mux: selected tally in result mode, zero otherwise or for an out-of-range index.
   always_comb begin
      result_d = '0;
      if (mode) begin
         for (int i = 0; i < NUM_CAND; i++) begin
            if (result_sel == 4'(i)) begin
               result_d = tally[i];
            end
         end
      end
   end

   // State, timer, pulse and readout registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         timer_q  <= '0;
         ack_q    <= 1'b0;
         rej_q    <= 1'b0;
         to_q     <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         ack_q    <= ack_d;
         rej_q    <= rej_d;
         to_q     <= to_d;
         result_q <= result_d;
      end
   end

   for (genvar g = 0; g < NUM_CAND; g++) begin : g_tally
      sat_counter #(.CNT_W(CNT_W)) u_tally (
         .clk   (clk),
         .reset (reset),
         .inc   (tally_inc[g]),
         .clr   (clear_en),
         .cnt_o (tally[g])
      );
   end

   sat_counter #(.CNT_W(CNT_W)) u_total (
      .clk   (clk),
      .reset (reset),
      .inc   (total_inc),
      .clr   (clear_en),
      .cnt_o (total_votes)
   );

   sat_counter #(.CNT_W(CNT_W)) u_reject (
      .clk   (clk),
      .reset (reset),
      .inc   (rej_inc),
      .clr   (clear_en),
      .cnt_o (reject_count)
   );

   assign ballot_ready   = (state_q == ARMED);
   assign vote_ack       = ack_q;
   assign vote_reject    = rej_q;
   assign ballot_timeout = to_q;
   assign result_count   = result_q;

endmodule
